// File: rtl/bus_rr_sched.sv
// Round-robin bus scheduler: grants one driver FIFO at a time, pops its head
// packet and pushes it to the decoded destination port(s) or to all other ports.
module bus_rr_sched #(
    parameter int         drvrs   = 4,
    parameter int         pckg_sz = 16,
    parameter logic [7:0] bdcst   = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [drvrs*pckg_sz-1:0]   D_push,
    output logic                       busy,
    output logic [3:0]                 grant_id,
    output logic                       drop,
    output logic [15:0]                pkt_cnt
);

    typedef enum logic [1:0] {IDLE, POP, DELIVER} state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 ptr_q, ptr_d;
    logic [3:0]                 grant_q, grant_d;
    logic [drvrs-1:0]           pop_q, pop_d;
    logic [drvrs-1:0]           push_q, push_d;
    logic [drvrs*pckg_sz-1:0]   dpush_q, dpush_d;
    logic                       busy_q, busy_d;
    logic                       drop_q, drop_d;
    logic [15:0]                cnt_q, cnt_d;

    logic [3:0]                 winner;
    logic                       found;
    int                         idx;
    logic [pckg_sz-1:0]         lane;
    logic [7:0]                 dest;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Search starts just past the last winner so each pending driver waits at most one round.
        for (int k = 1; k <= drvrs; k++) begin
            idx = (int'(ptr_q) + k) % drvrs;
            if (!found && pndng[idx]) begin
                winner = 4'(idx);
                found  = 1'b1;
            end
        end

        lane = '0;
        for (int i = 0; i < drvrs; i++)
            if (int'(grant_q) == i) lane = D_pop[i*pckg_sz +: pckg_sz];
        dest = lane[pckg_sz-1 -: 8];

        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        pop_d   = '0;
        push_d  = '0;
        dpush_d = dpush_q;
        drop_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    ptr_d   = winner;
                    for (int i = 0; i < drvrs; i++) pop_d[i] = (int'(winner) == i);
                    state_d = POP;
                end
            end
            POP: begin
                // Head word is still presented this cycle; decode it now so push lands next cycle.
                dpush_d = {drvrs{lane}};
                if (int'(dest) < drvrs) begin
                    for (int i = 0; i < drvrs; i++) push_d[i] = (int'(dest) == i);
                    cnt_d = cnt_q + 16'd1;
                end else if (dest == bdcst) begin
                    for (int i = 0; i < drvrs; i++) push_d[i] = (int'(grant_q) != i);
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    drop_d = 1'b1;
                end
                state_d = DELIVER;
            end
            DELIVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 4'(drvrs - 1);
            grant_q <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            dpush_q <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            dpush_q <= dpush_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = dpush_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign drop     = drop_q;
    assign pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_bus_rr_sched.sv
// Directed bench for bus_rr_sched: reset, unicast, round-robin, broadcast,
// invalid destination and mid-transaction reset.
module tb_bus_rr_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] D_pop;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [63:0] D_push;
    logic        busy;
    logic [3:0]  grant_id;
    logic        drop;
    logic [15:0] pkt_cnt;

    int checks = 0;
    int passed = 0;

    bus_rr_sched #(.drvrs(4), .pckg_sz(16), .bdcst(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push), .busy(busy),
        .grant_id(grant_id), .drop(drop), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pndng = 4'hF;
        D_pop = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (pop !== 4'b0 || push !== 4'b0 || busy !== 1'b0 || pkt_cnt !== 16'd0 ||
                drop !== 1'b0 || grant_id !== 4'd0)
                $display("FAIL reset_hold cyc%0d got pop=%b push=%b busy=%b cnt=%0d drop=%b gid=%0d exp all 0",
                         c, pop, push, busy, pkt_cnt, drop, grant_id);
            else passed++;
        end
    endtask

    task automatic test_unicast();
        reset = 1'b1;
        pndng = 4'b0100;
        D_pop = '0;
        D_pop[32 +: 16] = 16'h01AB;
        tick();
        pndng = 4'b0000;
        checks++;
        if (pop !== 4'b0100 || busy !== 1'b1 || grant_id !== 4'd2)
            $display("FAIL unicast_pop got pop=%b busy=%b gid=%0d exp 0100 1 2", pop, busy, grant_id);
        else passed++;
        tick();
        checks++;
        if (push !== 4'b0010 || pop !== 4'b0000 || D_push !== {4{16'h01AB}} || pkt_cnt !== 16'd1)
            $display("FAIL unicast_push got push=%b pop=%b dpush=%h cnt=%0d exp 0010 0000 01ab*4 1",
                     push, pop, D_push, pkt_cnt);
        else passed++;
        tick();
        checks++;
        if (push !== 4'b0 || busy !== 1'b0 || D_push !== {4{16'h01AB}})
            $display("FAIL unicast_idle got push=%b busy=%b dpush=%h exp 0000 0 hold", push, busy, D_push);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        pndng = 4'hF;
        for (int i = 0; i < 4; i++) D_pop[i*16 +: 16] = {8'h00, 8'(i)};
        for (int g = 0; g < 8; g++) begin
            exp_oh = 4'b0001 << (g % 4);
            tick();
            checks++;
            if (pop !== exp_oh || grant_id !== 4'(g % 4))
                $display("FAIL rr_pop g%0d got pop=%b gid=%0d exp %b %0d", g, pop, grant_id, exp_oh, g % 4);
            else passed++;
            tick();
            checks++;
            if (push !== 4'b0001 || D_push[15:0] !== {8'h00, 8'(g % 4)})
                $display("FAIL rr_push g%0d got push=%b lane0=%h exp 0001 %h", g, push, D_push[15:0],
                         {8'h00, 8'(g % 4)});
            else passed++;
            tick();
        end
        checks++;
        if (pkt_cnt !== 16'd8)
            $display("FAIL rr_count got %0d exp 8", pkt_cnt);
        else passed++;
    endtask

    task automatic test_broadcast();
        pndng = 4'b0010;
        D_pop = '0;
        D_pop[16 +: 16] = 16'hFF55;
        tick();
        pndng = 4'b0;
        checks++;
        if (pop !== 4'b0010)
            $display("FAIL bcast_pop got %b exp 0010", pop);
        else passed++;
        tick();
        checks++;
        if (push !== 4'b1101 || D_push !== {4{16'hFF55}} || drop !== 1'b0 || pkt_cnt !== 16'd9)
            $display("FAIL bcast_push got push=%b dpush=%h drop=%b cnt=%0d exp 1101 ff55*4 0 9",
                     push, D_push, drop, pkt_cnt);
        else passed++;
        tick();
    endtask

    task automatic test_invalid();
        pndng = 4'b1000;
        D_pop = '0;
        D_pop[48 +: 16] = 16'h0A00;
        tick();
        pndng = 4'b0;
        checks++;
        if (pop !== 4'b1000)
            $display("FAIL inval_pop got %b exp 1000", pop);
        else passed++;
        tick();
        checks++;
        if (drop !== 1'b1 || push !== 4'b0 || pkt_cnt !== 16'd9)
            $display("FAIL inval_drop got drop=%b push=%b cnt=%0d exp 1 0000 9", drop, push, pkt_cnt);
        else passed++;
        tick();
        checks++;
        if (drop !== 1'b0 || busy !== 1'b0)
            $display("FAIL inval_after got drop=%b busy=%b exp 0 0", drop, busy);
        else passed++;
    endtask

    task automatic test_midop_reset();
        pndng = 4'b0100;
        D_pop = '0;
        D_pop[0 +: 16]  = 16'h0312;
        D_pop[32 +: 16] = 16'h0000;
        tick();
        checks++;
        if (pop !== 4'b0100)
            $display("FAIL midrst_pop got %b exp 0100", pop);
        else passed++;
        reset = 1'b0;
        tick();
        checks++;
        if (push !== 4'b0 || pop !== 4'b0 || busy !== 1'b0 || pkt_cnt !== 16'd0)
            $display("FAIL midrst_abort got push=%b pop=%b busy=%b cnt=%0d exp 0 0 0 0", push, pop, busy, pkt_cnt);
        else passed++;
        reset = 1'b1;
        pndng = 4'hF;
        tick();
        checks++;
        if (pop !== 4'b0001 || grant_id !== 4'd0 || push !== 4'b0)
            $display("FAIL midrst_regrant got pop=%b gid=%0d push=%b exp 0001 0 0000", pop, grant_id, push);
        else passed++;
        pndng = 4'b0;
        tick();
        checks++;
        if (push !== 4'b1000 || D_push[15:0] !== 16'h0312 || pkt_cnt !== 16'd1)
            $display("FAIL midrst_push got push=%b lane0=%h cnt=%0d exp 1000 0312 1", push, D_push[15:0], pkt_cnt);
        else passed++;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        test_reset();
        test_unicast();
        test_round_robin();
        test_broadcast();
        test_invalid();
        test_midop_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
